// File: rtl/gauss_window_regs.sv
// gauss_window_regs: K*K pixel window with load mask and filter handoff FSM.
// Define GAUSS_WIN_SHIFT_EN to enable column-slide loading through shift_i/col_i.
module gauss_window_regs #(
  parameter int PIX_W  = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [PIX_W-1:0]       in_pixel,
  input  logic                   shift_i,
  input  logic [K*PIX_W-1:0]     col_i,
  input  logic                   win_ready_i,
  input  logic                   res_valid_i,
  input  logic [PIX_W-1:0]       in_procesado,
  output logic [K*K*PIX_W-1:0]   win_o,
  output logic                   win_valid_o,
  output logic                   busy_o,
  output logic [31:0]            out_d
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int N = K * K;

  logic [1:0]           state, state_n;
  logic [N*PIX_W-1:0]   win_q, win_n;
  logic [N-1:0]         mask_q, mask_n;
  logic                 shift, wr_ok;

`ifdef GAUSS_WIN_SHIFT_EN
  assign shift = shift_i;
`else
  logic unused_shift;
  assign unused_shift = shift_i;
  assign shift = 1'b0;
`endif

  assign wr_ok = we && addr_i != '0 && addr_i <= ADDR_W'(N);

  // Shift wins over a same-cycle write; BUSY freezes the window.
  always_comb begin
    win_n  = win_q;
    mask_n = mask_q;
    if (state != BUSY) begin
      if (shift) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) begin
            win_n[(r*K+c)*PIX_W +: PIX_W] = (c == K-1) ? col_i[r*PIX_W +: PIX_W]
                                                       : win_q[((r*K+c+1) % N)*PIX_W +: PIX_W];
            mask_n[r*K+c] = (c == K-1) | mask_q[(r*K+c+1) % N];
          end
      end else if (wr_ok) begin
        for (int i = 0; i < N; i++)
          if (addr_i == ADDR_W'(i+1)) begin
            win_n[i*PIX_W +: PIX_W] = in_pixel;
            mask_n[i] = 1'b1;
          end
      end
    end
  end

  always_comb begin
    state_n = state == EMPTY ? (&mask_n ? FULL : EMPTY) :
              state == FULL  ? (win_ready_i ? BUSY : FULL) :
              state == BUSY  ? (res_valid_i ? DONE : BUSY) :
              (we | shift)   ? (&mask_n ? FULL : EMPTY) : DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      win_q  <= '0;
      mask_q <= '0;
      out_d  <= '0;
    end else begin
      state  <= state_n;
      win_q  <= win_n;
      mask_q <= mask_n;
      if (state == FULL && win_ready_i) out_d[31] <= 1'b0;
      if (state == BUSY && res_valid_i) out_d <= {1'b1, {(31-PIX_W){1'b0}}, in_procesado};
    end
  end

  assign win_o       = win_q;
  assign win_valid_o = state == FULL;
  assign busy_o      = state == BUSY;
endmodule

// File: tb/tb_gauss_window_regs.sv
// tb_gauss_window_regs: directed checks of gauss_window_regs with K=3, PIX_W=8.
module tb_gauss_window_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [5:0]  addr_i = '0;
  logic [7:0]  in_pixel = '0;
  logic        shift_i = 1'b0;
  logic [23:0] col_i = '0;
  logic        win_ready_i = 1'b0;
  logic        res_valid_i = 1'b0;
  logic [7:0]  in_procesado = '0;
  logic [71:0] win_o;
  logic        win_valid_o, busy_o;
  logic [31:0] out_d;
  logic [71:0] exp_win;
  int          n_chk = 0;
  int          n_pass = 0;

  gauss_window_regs #(.PIX_W(8), .K(3), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .we(we), .addr_i(addr_i), .in_pixel(in_pixel),
    .shift_i(shift_i), .col_i(col_i), .win_ready_i(win_ready_i),
    .res_valid_i(res_valid_i), .in_procesado(in_procesado), .win_o(win_o),
    .win_valid_o(win_valid_o), .busy_o(busy_o), .out_d(out_d)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    we = 1'b1; addr_i = a; in_pixel = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_win", win_o, 72'h0);
    check("rst_valid", {71'h0, win_valid_o}, 72'h0);
    check("rst_busy", {71'h0, busy_o}, 72'h0);
    check("rst_out", {40'h0, out_d}, 72'h0);

    wr(6'd0, 8'hFF);
    wr(6'd10, 8'hEE);
    check("bad_addr_win", win_o, 72'h0);
    check("bad_addr_valid", {71'h0, win_valid_o}, 72'h0);

    exp_win = '0;
    for (int i = 0; i < 8; i++) begin
      wr(6'(i + 1), 8'(8'h10 + i));
      exp_win[i*8 +: 8] = 8'(8'h10 + i);
    end
    check("eight_valid", {71'h0, win_valid_o}, 72'h0);
`ifndef GAUSS_WIN_SHIFT_EN
    shift_i = 1'b1; col_i = 24'h332211;
    step();
    shift_i = 1'b0; col_i = '0;
    check("noshift_win", win_o, exp_win);
    check("noshift_valid", {71'h0, win_valid_o}, 72'h0);
`endif
    wr(6'd9, 8'h18);
    exp_win[64 +: 8] = 8'h18;
    check("full_valid", {71'h0, win_valid_o}, 72'h1);
    check("full_idx0", {64'h0, win_o[7:0]}, 72'h10);
    check("full_idx8", {64'h0, win_o[71:64]}, 72'h18);
    check("full_win", win_o, exp_win);

    res_valid_i = 1'b1; in_procesado = 8'h77;
    step();
    res_valid_i = 1'b0;
    check("res_ignored_out", {40'h0, out_d}, 72'h0);
    check("res_ignored_valid", {71'h0, win_valid_o}, 72'h1);

    win_ready_i = 1'b1;
    step();
    win_ready_i = 1'b0;
    check("busy_set", {71'h0, busy_o}, 72'h1);
    check("busy_valid", {71'h0, win_valid_o}, 72'h0);
    wr(6'd5, 8'hAA);
    check("busy_frozen", win_o, exp_win);
    check("busy_hold", {71'h0, busy_o}, 72'h1);

    res_valid_i = 1'b1; in_procesado = 8'h3C;
    step();
    res_valid_i = 1'b0;
    check("done_out", {40'h0, out_d}, 72'h8000003C);
    check("done_busy", {71'h0, busy_o}, 72'h0);
    check("done_valid", {71'h0, win_valid_o}, 72'h0);
    step();
    check("done_idle_valid", {71'h0, win_valid_o}, 72'h0);
    win_ready_i = 1'b1;
    step();
    win_ready_i = 1'b0;
    check("ready_in_done", {71'h0, busy_o}, 72'h0);

    wr(6'd5, 8'hAA);
    exp_win[32 +: 8] = 8'hAA;
    check("done_to_full", {71'h0, win_valid_o}, 72'h1);
    check("done_write", win_o, exp_win);
    check("out_kept", {40'h0, out_d}, 72'h8000003C);
    win_ready_i = 1'b1;
    step();
    win_ready_i = 1'b0;
    check("flag_cleared", {40'h0, out_d}, 72'h3C);

    rst = 1'b1; res_valid_i = 1'b1; in_procesado = 8'h99;
    step();
    rst = 1'b0; res_valid_i = 1'b0;
    check("rst_busy_out", {40'h0, out_d}, 72'h0);
    check("rst_busy_win", win_o, 72'h0);
    check("rst_busy_state", {70'h0, busy_o, win_valid_o}, 72'h0);

`ifdef GAUSS_WIN_SHIFT_EN
    for (int i = 0; i < 9; i++) wr(6'(i + 1), 8'(8'h10 + i));
    win_ready_i = 1'b1;
    step();
    win_ready_i = 1'b0;
    res_valid_i = 1'b1; in_procesado = 8'h01;
    step();
    res_valid_i = 1'b0;
    we = 1'b1; addr_i = 6'd1; in_pixel = 8'h55; shift_i = 1'b1; col_i = 24'h332211;
    step();
    we = 1'b0; shift_i = 1'b0;
    check("shift_idx0", {64'h0, win_o[7:0]}, 72'h11);
    check("shift_col2", {48'h0, win_o[71:64], win_o[47:40], win_o[23:16]}, 72'h332211);
    check("shift_full", {71'h0, win_valid_o}, 72'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gauss_window_regs.md
GAUSS_WINDOW_REGS -- requirements
Module: gauss_window_regs

Interface
REQ-001 Parameter PIX_W, default 8: pixel and result width; legal range 1..16.
REQ-002 Parameter K, default 3: window side; odd; legal range 3..7; window holds K*K pixels.
REQ-003 Parameter ADDR_W, default 6: address width; 2**ADDR_W SHALL be greater than K*K.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 we  in  1  write strobe for one window pixel.
REQ-007 addr_i  in  ADDR_W  pixel address; 1..K*K maps to window index addr_i-1 in row-major order.
REQ-008 in_pixel  in  PIX_W  pixel data written when we=1.
REQ-009 shift_i  in  1  slide strobe; shifts the window left by one column.
REQ-010 col_i  in  K*PIX_W  new right-hand column; row r occupies bits [r*PIX_W +: PIX_W].
REQ-011 win_ready_i  in  1  filter accepts the current window.
REQ-012 res_valid_i  in  1  filter result strobe.
REQ-013 in_procesado  in  PIX_W  filtered result from the filter.
REQ-014 win_o  out  K*K*PIX_W  window; index i occupies bits [i*PIX_W +: PIX_W].
REQ-015 win_valid_o  out  1  window complete and offered to the filter.
REQ-016 busy_o  out  1  window handed off; result pending.
REQ-017 out_d  out  32  status/result word.

Function
REQ-018 A loaded mask of K*K bits SHALL track which window entries hold valid data.
REQ-019 A write with we=1 and addr_i in 1..K*K SHALL store in_pixel at index addr_i-1 and set the matching mask bit.
REQ-020 A write with addr_i=0 or addr_i>K*K SHALL be ignored, with no wrap-around and no underflow.
REQ-021 A shift SHALL move column c+1 into column c for c=0..K-2, load col_i into column K-1, and shift the mask the same way with the mask bits of column K-1 set.
REQ-022 When we and shift_i are both 1 in the same cycle, the shift SHALL take effect and the write SHALL be dropped.
REQ-023 The FSM SHALL have four states: EMPTY, FULL, BUSY and DONE; its reset state SHALL be EMPTY.
REQ-024 From EMPTY, the FSM SHALL go to FULL in the cycle after the update that makes the mask all-ones.
REQ-025 In FULL, writes and shifts SHALL still update the window, and win_ready_i=1 SHALL move the FSM to BUSY.
REQ-026 In BUSY, the window SHALL be frozen and all writes and shifts SHALL be ignored.
REQ-027 In BUSY, res_valid_i=1 SHALL move the FSM to DONE and latch in_procesado.
REQ-028 In DONE, a write or shift SHALL update the window, then move the FSM to FULL if the mask is all-ones and to EMPTY otherwise.
REQ-029 In DONE, with no write or shift, the FSM SHALL stay in DONE.
REQ-030 win_valid_o SHALL equal (state==FULL), and busy_o SHALL equal (state==BUSY); both SHALL be registered-state decodes with no combinational path from the inputs.
REQ-031 res_valid_i outside BUSY SHALL be ignored, and win_ready_i outside FULL SHALL be ignored.
REQ-032 out_d[PIX_W-1:0] SHALL hold the last latched result.
REQ-033 out_d[31] SHALL be set when a result is latched and cleared on the next FULL-to-BUSY handoff.
REQ-034 All other out_d bits SHALL be 0, and out_d SHALL update one cycle after the latching edge.

Reset
REQ-035 rst=1 SHALL, on the next clock edge, clear all window entries, the mask and out_d to 0, and set the state to EMPTY, regardless of the current state.
REQ-036 rst SHALL take priority over every other input in the same cycle, and a pending result SHALL be discarded.
REQ-037 After reset, win_o=0, win_valid_o=0, busy_o=0 and out_d=0.

Configuration
REQ-038 The macro GAUSS_WIN_SHIFT_EN SHALL gate slide mode: when defined, shift_i and col_i SHALL behave as in REQ-021 and REQ-022.
REQ-039 When GAUSS_WIN_SHIFT_EN is undefined, the shift_i and col_i ports SHALL remain present but be ignored, and windows SHALL load only through addressed writes.

Verification
REQ-040 Scenario (K=3, PIX_W=8): write addresses 1..9 with 0x10..0x18 -> win_valid_o=1 in the cycle after the 9th write, and win_o index 0 = 0x10, index 8 = 0x18.
REQ-041 Scenario: write address 0 with 0xFF, then address 10 with 0xEE -> window and mask unchanged, state stays EMPTY.
REQ-042 Scenario: window FULL, pulse win_ready_i, write address 5 with 0xAA, pulse res_valid_i with in_procesado=0x3C -> busy_o=1 during the wait, index 4 unchanged, then state DONE, out_d=0x8000003C.
REQ-043 Scenario (GAUSS_WIN_SHIFT_EN defined): window in DONE, assert we (address 1, 0x55) and shift_i together with col_i={0x33,0x22,0x11} -> write dropped, column 2 = 0x11/0x22/0x33, state FULL.
REQ-044 Scenario: assert rst while in BUSY with res_valid_i=1 -> next cycle state EMPTY, out_d=0, win_o=0.
REQ-045 Scenario (GAUSS_WIN_SHIFT_EN undefined): pulse shift_i with nonzero col_i from EMPTY -> window and mask unchanged.
